// File: rtl/hex_ascii_word_parser.sv
// hex_ascii_word_parser
// Assembles a stream of ASCII hex digits into a binary word. Words are
// delimited by CR, LF or space and handed downstream on a valid/ready port.
// A malformed token raises a one-cycle error pulse with a sticky code, and
// the rest of that token is dropped up to the next terminator.
module hex_ascii_word_parser #(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   char_in,
    input  logic                         char_valid,
    output logic                         char_ready,
    output logic [4*DIGITS-1:0]          word_out,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         err,
    output logic [1:0]                   err_code
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    word_q, word_d;
    logic [CW-1:0]   dcount_q, dcount_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [1:0]      errCode_q, errCode_d;

    logic            isDigit;
    logic            isTerm;
    logic [3:0]      nibble;
    logic            accept;

    // Classify the incoming character as hex digit, terminator or invalid.
    always_comb begin
        isDigit = 1'b0;
        isTerm  = 1'b0;
        nibble  = 4'd0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            isDigit = 1'b1;
            nibble  = char_in[3:0];
        end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                     (char_in >= 8'h61 && char_in <= 8'h66)) begin
            isDigit = 1'b1;
            nibble  = char_in[3:0] + 4'd9;
        end else if (char_in == 8'h0D || char_in == 8'h0A || char_in == 8'h20) begin
            isTerm  = 1'b1;
        end
    end

    assign accept = char_valid && char_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic together with the accumulator and output-register updates.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        word_d    = word_q;
        dcount_d  = dcount_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        errCode_d = errCode_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (isDigit) begin
                        if (count_q == CW'(DIGITS)) begin
                            err_d     = 1'b1;
                            errCode_d = 2'b01;
                            acc_d     = '0;
                            count_d   = '0;
                            state_d   = SKIP;
                        end else begin
                            acc_d   = (acc_q << 4) | W'(nibble);
                            count_d = count_q + CW'(1);
                            state_d = ACCUM;
                        end
                    end else if (isTerm) begin
                        if (state_q == ACCUM) begin
                            word_d   = acc_q;
                            dcount_d = count_q;
                            valid_d  = 1'b1;
                            state_d  = HOLD;
                        end
                    end else begin
                        err_d     = 1'b1;
                        errCode_d = 2'b10;
                        acc_d     = '0;
                        count_d   = '0;
                        state_d   = SKIP;
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            SKIP: begin
                if (accept && isTerm) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; word and count persist after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            count_q   <= '0;
            word_q    <= '0;
            dcount_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            errCode_q <= 2'b00;
        end else begin
            acc_q     <= acc_d;
            count_q   <= count_d;
            word_q    <= word_d;
            dcount_q  <= dcount_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            errCode_q <= errCode_d;
        end
    end

    // Output decode: input is stalled only while a word waits for downstream.
    always_comb begin
        char_ready  = (state_q != HOLD);
        word_out    = word_q;
        digit_count = dcount_q;
        word_valid  = valid_q;
        err         = err_q;
        err_code    = errCode_q;
    end

endmodule

// File: tb/tb_hex_ascii_word_parser.sv
// Testbench for hex_ascii_word_parser: directed scenarios plus random token
// streams, checked by a token-level reference model through a scoreboard.
module tb_hex_ascii_word_parser;

    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] w;
        int          n;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [15:0] word_out;
    logic [2:0]  digit_count;
    logic        word_valid;
    logic        word_ready;
    logic        err;
    logic [1:0]  err_code;

    int   checks;
    int   failures;
    int   readyMode;
    int   expLastCode;
    exp_t wordQ[$];
    int   errQ[$];

    hex_ascii_word_parser #(.DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .word_out    (word_out),
        .digit_count (digit_count),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .err         (err),
        .err_code    (err_code)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: bump the counters and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value of a hex digit, or -1 when the character is not one.
    function automatic int hexVal(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic bit isTermChar(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20);
    endfunction

    // Judge one whole token: either a word, or the first error that spoils it.
    task automatic evalToken(input logic [7:0] tok[$]);
        int   nd;
        int   v;
        exp_t e;
        if (tok.size() == 0) return;
        nd = 0;
        v  = 0;
        foreach (tok[i]) begin
            if (hexVal(tok[i]) < 0) begin
                errQ.push_back(2);
                return;
            end
            nd++;
            if (nd > DIGITS) begin
                errQ.push_back(1);
                return;
            end
            v = v * 16 + hexVal(tok[i]);
        end
        e.w = v[15:0];
        e.n = nd;
        wordQ.push_back(e);
    endtask

    // Split a character sequence into terminated tokens; an unterminated tail yields nothing.
    task automatic modelSeq(input logic [7:0] q[$]);
        logic [7:0] tok[$];
        tok = {};
        foreach (q[i]) begin
            if (isTermChar(q[i])) begin
                evalToken(tok);
                tok = {};
            end else begin
                tok.push_back(q[i]);
            end
        end
    endtask

    // Present one character and hold it until the parser takes it.
    task automatic sendChar(input logic [7:0] c);
        int t;
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            char_valid = 1'b0;
        end
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        t = 0;
        while (!char_ready) begin
            @(negedge clk);
            t++;
            if (t > 300) begin
                checks++;
                failures++;
                $display("[TB] FAIL char_accept_timeout actual=stalled required=accepted");
                break;
            end
        end
        @(posedge clk);
    endtask

    // Model a sequence, then drive it into the DUT.
    task automatic applyStimulus(input logic [7:0] q[$]);
        modelSeq(q);
        foreach (q[i]) sendChar(q[i]);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic applyString(input string s);
        logic [7:0] q[$];
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        applyStimulus(q);
    endtask

    function automatic logic [7:0] randHex();
        string hs;
        hs = "0123456789ABCDEFabcdef";
        return hs[$urandom_range(0, 21)];
    endfunction

    function automatic logic [7:0] randInvalid();
        string bs;
        bs = "GZgz-x!.";
        return bs[$urandom_range(0, 7)];
    endfunction

    function automatic logic [7:0] randTerm();
        case ($urandom_range(0, 2))
            0:       return 8'h0D;
            1:       return 8'h0A;
            default: return 8'h20;
        endcase
    endfunction

    // Random stream of good words, over-long words, bad tokens and bare terminators.
    task automatic genRandom(output logic [7:0] q[$]);
        int kind;
        int len;
        int badPos;
        q = {};
        repeat (6) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1, 2: begin
                    len = $urandom_range(1, DIGITS);
                    repeat (len) q.push_back(randHex());
                end
                3: begin
                    len = $urandom_range(DIGITS + 1, DIGITS + 3);
                    repeat (len) q.push_back(randHex());
                end
                4: begin
                    len    = $urandom_range(1, DIGITS);
                    badPos = $urandom_range(0, len - 1);
                    for (int i = 0; i < len; i++)
                        q.push_back((i == badPos) ? randInvalid() : randHex());
                end
                default: ;
            endcase
            repeat ($urandom_range(1, 2)) q.push_back(randTerm());
        end
    endtask

    // Wait for every expected response to be observed, then confirm nothing is left.
    task automatic drain();
        int t;
        readyMode = 2;
        t = 0;
        while ((wordQ.size() != 0 || errQ.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput("pending_words", wordQ.size(), 0);
        checkOutput("pending_errors", errQ.size(), 0);
    endtask

    // Downstream ready: random, forced low or forced high.
    initial begin
        word_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       word_ready = 1'($urandom_range(0, 1));
                1:       word_ready = 1'b0;
                default: word_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each word handshake and each error pulse.
    initial begin
        bit          prevValid;
        bit          prevReady;
        logic [15:0] prevWord;
        logic [2:0]  prevCnt;
        exp_t        e;
        int          code;
        prevValid = 0;
        prevReady = 0;
        prevWord  = '0;
        prevCnt   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prevValid = 0;
            end else begin
                if (word_valid) begin
                    checkOutput("hold_char_ready", char_ready, 0);
                    if (prevValid && !prevReady) begin
                        checkOutput("word_stable", word_out, prevWord);
                        checkOutput("count_stable", digit_count, prevCnt);
                    end
                    if (word_ready) begin
                        if (wordQ.size() == 0) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL unexpected_word actual=%0h required=none", word_out);
                        end else begin
                            e = wordQ.pop_front();
                            checkOutput("word_out", word_out, e.w);
                            checkOutput("digit_count", digit_count, e.n);
                        end
                    end
                end
                if (err) begin
                    if (errQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_err actual=%0d required=none", err_code);
                    end else begin
                        code = errQ.pop_front();
                        checkOutput("err_code", err_code, code);
                        expLastCode = code;
                    end
                end else begin
                    checkOutput("err_code_hold", err_code, expLastCode);
                end
                prevValid = word_valid;
                prevReady = word_ready;
                prevWord  = word_out;
                prevCnt   = digit_count;
            end
        end
    end

    // Main sequence: reset, directed scenarios, random streams, summary.
    initial begin
        logic [7:0] rq[$];
        checks      = 0;
        failures    = 0;
        readyMode   = 2;
        expLastCode = 0;
        rst         = 1'b1;
        char_in     = 8'h00;
        char_valid  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_char_ready", char_ready, 1);
        checkOutput("reset_word_valid", word_valid, 0);
        checkOutput("reset_word_out", word_out, 0);
        checkOutput("reset_digit_count", digit_count, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_err_code", err_code, 0);
        @(negedge clk);
        rst = 1'b0;

        applyString("1A3f\015");
        applyString("7\015\012 \015");
        applyString("12345 BEEF\015");
        applyString("1G2\015C\015");
        drain();

        // Stall downstream for five cycles while '9' waits on the input.
        readyMode = 1;
        applyString("AB\015");
        modelSeq('{8'h39, 8'h0D});
        fork
            begin
                sendChar(8'h39);
                sendChar(8'h0D);
                @(negedge clk);
                char_valid = 1'b0;
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    checkOutput("stall_char_ready", char_ready, 0);
                    checkOutput("stall_word_valid", word_valid, 1);
                    checkOutput("stall_word_out", word_out, 16'h00AB);
                end
                readyMode = 2;
            end
        join
        drain();

        // Asynchronous reset in the middle of a partial word.
        applyString("12");
        #2;
        rst         = 1'b1;
        expLastCode = 0;
        #1;
        checkOutput("midreset_char_ready", char_ready, 1);
        checkOutput("midreset_word_valid", word_valid, 0);
        checkOutput("midreset_word_out", word_out, 0);
        checkOutput("midreset_digit_count", digit_count, 0);
        checkOutput("midreset_err_code", err_code, 0);
        @(negedge clk);
        rst = 1'b0;
        applyString("3\015");
        drain();

        readyMode = 0;
        repeat (40) begin
            genRandom(rq);
            applyStimulus(rq);
            readyMode = 0;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
